// File: rtl/load_store_unit.sv
// Load/store unit: turns CPU byte/half/word requests into word-wide memory strobes.
// Sub-word stores use read-modify-write. Define LSU_ALIGN_CHECK_EN to reject misaligned or reserved-size requests.
module load_store_unit #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] addr,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] WrData,
    input  logic [31:0] data
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_RESP} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_write;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic [15:0] r_wdata_lo;
    logic [1:0]  r_wait_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wrdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_misalign;
    logic        w_wait_done;
    logic [3:0]  w_lane_en;
    logic [31:0] w_store_rep;
    logic [31:0] w_merged;
    logic [31:0] w_load_val;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_accept    = req_valid & req_ready;
    assign w_wait_done = (r_wait_cnt == 2'd0);

`ifdef LSU_ALIGN_CHECK_EN
    assign w_misalign = (req_size == 2'b11) ||
                        (req_size == 2'b01 && req_addr[0]) ||
                        (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        resp_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by rst so the unit never advertises readiness while held in reset.
                req_ready = rst;
                if (w_accept) begin
                    if (w_misalign)
                        w_state_next = S_RESP;
                    else if (req_write && req_size[1])
                        w_state_next = S_WR;
                    else
                        w_state_next = S_RD;
                end
            end
            S_RD: begin
                MemRead      = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_wait_done)
                    w_state_next = r_write ? S_WR : S_RESP;
            end
            S_WR: begin
                MemWrite     = 1'b1;
                w_state_next = S_RESP;
            end
            S_RESP: begin
                resp_valid   = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Lanes replaced by a sub-word store; size[1] (word) never reaches the merge path.
    always_comb begin
        if (r_size[0])
            w_lane_en = r_off[1] ? 4'b1100 : 4'b0011;
        else
            w_lane_en = 4'b0001 << r_off;
        w_store_rep = r_size[0] ? {2{r_wdata_lo}} : {4{r_wdata_lo[7:0]}};
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_merged[8*gi +: 8] = w_lane_en[gi] ? w_store_rep[8*gi +: 8] : data[8*gi +: 8];
    end

    assign w_byte = data[{r_off, 3'b000} +: 8];
    assign w_half = data[{r_off[1], 4'b0000} +: 16];

    always_comb begin
        w_load_val = data;
        if (!r_size[1]) begin
            if (r_size[0])
                w_load_val = {{16{r_signed & w_half[15]}}, w_half};
            else
                w_load_val = {{24{r_signed & w_byte[7]}}, w_byte};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_write    <= 1'b0;
            r_signed   <= 1'b0;
            r_size     <= 2'b00;
            r_off      <= 2'b00;
            r_wdata_lo <= 16'h0;
            r_wait_cnt <= 2'd0;
            r_addr     <= 32'h0;
            r_wrdata   <= 32'h0;
            r_rdata    <= 32'h0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write    <= req_write;
                r_signed   <= req_signed;
                r_size     <= req_size;
                r_off      <= req_addr[1:0];
                r_wdata_lo <= req_wdata[15:0];
                r_addr     <= {req_addr[31:2], 2'b00};
                r_err      <= w_misalign;
            end

            if (r_state == S_RD)
                r_wait_cnt <= 2'(RD_LATENCY - 1);
            else if (r_state == S_WAIT && !w_wait_done)
                r_wait_cnt <= r_wait_cnt - 2'd1;

            if (w_accept && !w_misalign && req_write && req_size[1])
                r_wrdata <= req_wdata;
            else if (r_state == S_WAIT && w_wait_done && r_write)
                r_wrdata <= w_merged;

            // Only a load enters RESP from WAIT; every other path reports zero data.
            if (w_state_next == S_RESP && r_state != S_RESP)
                r_rdata <= (r_state == S_WAIT) ? w_load_val : 32'h0;
        end
    end

    assign addr       = r_addr;
    assign WrData     = r_wrdata;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a transaction-level model predicts strobes, latency and results,
// and one per-cycle compare process checks the DUT against it.
module tb_load_store_unit;
    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, MemRead, MemWrite;
    logic [31:0] resp_rdata, addr, WrData, data;

    always #5 clk = ~clk;

    load_store_unit #(.RD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .addr(addr), .MemRead(MemRead), .MemWrite(MemWrite),
        .WrData(WrData), .data(data)
    );

    // Memory model: 64 words, read data appears LAT cycles after the MemRead cycle.
    logic [31:0] mem [64];
    logic [31:0] rd_pipe [LAT];
    logic        poke_en = 1'b0;
    logic [5:0]  poke_idx = 6'd0;
    logic [31:0] poke_val = 32'h0;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h9E3779B9 * 32'(i + 1);
        end else begin
            if (MemWrite) mem[addr[7:2]] <= WrData;
            if (poke_en) mem[poke_idx] <= poke_val;
        end
        rd_pipe[0] <= MemRead ? mem[addr[7:2]] : $urandom;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign data = rd_pipe[LAT-1];

    // Expected transaction, written only by the driver.
    int          issued_cnt = 0, abort_cnt = 0, done_cnt = 0;
    int          t_acc = 0, n_total = 0, wr_phase = 0;
    bit          tx_rd = 0, tx_wr = 0;
    logic [31:0] e_addr = 0, e_wrdata = 0, e_rdata = 0;
    logic        e_err = 0;
    int          pin_kind = 0, pin_lat = 0;
    logic [31:0] pin_val = 0;

    int          checks = 0, failures = 0;
    logic [31:0] last_rdata = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        int n;
        bit act, exp_rd, exp_wr, exp_rv;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                chk("reset_req_ready", 32'(req_ready), 32'd0);
                chk("reset_strobes", 32'({MemRead, MemWrite, resp_valid, resp_err}), 32'd0);
                chk("reset_rdata", resp_rdata, 32'd0);
                chk("reset_addr", addr, 32'd0);
                chk("reset_wrdata", WrData, 32'd0);
                last_rdata = 32'd0;
            end else begin
                n      = cyc - t_acc + 1;
                act    = (issued_cnt != done_cnt + abort_cnt) && (n >= 1);
                exp_rd = act && tx_rd && (n == 1);
                exp_wr = act && tx_wr && (n == wr_phase);
                exp_rv = act && (n == n_total);
                chk("req_ready", 32'(req_ready), 32'(!act));
                chk("MemRead", 32'(MemRead), 32'(exp_rd));
                chk("MemWrite", 32'(MemWrite), 32'(exp_wr));
                chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
                if (exp_rd || exp_wr) chk("mem_addr", addr, e_addr);
                if (exp_wr) chk("WrData", WrData, e_wrdata);
                if (exp_rv) begin
                    chk("resp_rdata", resp_rdata, e_rdata);
                    chk("resp_err", 32'(resp_err), 32'(e_err));
                    case (pin_kind)
                        1: chk("pin_rdata", e_rdata, pin_val);
                        2: chk("pin_wrdata", e_wrdata, pin_val);
                        3: chk("pin_err", 32'(e_err), pin_val);
                        4: chk("pin_addr", e_addr, pin_val);
                        default: ;
                    endcase
                    if (pin_lat != 0) chk("pin_latency", 32'(n_total), 32'(pin_lat));
                    last_rdata = e_rdata;
                    done_cnt++;
                end else begin
                    chk("rdata_hold", resp_rdata, last_rdata);
                end
            end
        end
    end

    task automatic poke(input logic [5:0] idx, input logic [31:0] val);
        poke_idx = idx;
        poke_val = val;
        poke_en  = 1'b1;
        @(negedge clk);
        poke_en  = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input int pk, input logic [31:0] pv, input int pl,
                         input int abort_ph);
        logic [31:0] word, v, mask;
        logic [1:0]  esz;
        logic        err;
        int          sh;
        word = mem[a[7:2]];
        esz  = (sz == 2'b11) ? 2'b10 : sz;
`ifdef LSU_ALIGN_CHECK_EN
        err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`else
        err = 1'b0;
`endif
        e_addr = {a[31:2], 2'b00};
        e_err  = err;
        e_rdata = 32'h0;
        sh = (esz == 2'b01) ? 16 * int'(a[1]) : 8 * int'(a[1:0]);
        mask = (esz == 2'b01) ? (32'hFFFF << sh) : (32'hFF << sh);
        if (err) begin
            tx_rd = 0; tx_wr = 0; wr_phase = 0; n_total = 1;
        end else if (!w) begin
            tx_rd = 1; tx_wr = 0; wr_phase = 0; n_total = 2 + LAT;
            if (esz == 2'b10) begin
                v = word;
            end else begin
                v = (word & mask) >> sh;
                if (sg && esz == 2'b01 && v[15]) v = v | 32'hFFFF0000;
                if (sg && esz == 2'b00 && v[7])  v = v | 32'hFFFFFF00;
            end
            e_rdata = v;
        end else if (esz == 2'b10) begin
            tx_rd = 0; tx_wr = 1; wr_phase = 1; n_total = 2;
            e_wrdata = wd;
        end else begin
            tx_rd = 1; tx_wr = 1; wr_phase = 2 + LAT; n_total = 3 + LAT;
            e_wrdata = (word & ~mask) | ((wd << sh) & mask);
        end
        pin_kind = pk; pin_val = pv; pin_lat = pl;

        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        t_acc = cyc + 1;
        issued_cnt++;

        for (int k = 1; k <= n_total; k++) begin
            @(negedge clk);
            if (k == abort_ph) begin
                req_valid = 1'b0;
                #2;
                rst = 1'b0;
                abort_cnt++;
                repeat (2) @(negedge clk);
                #2;
                rst = 1'b1;
                @(negedge clk);
                return;
            end
            // Requests while busy must be ignored.
            req_valid  = 1'($urandom);
            req_write  = 1'($urandom);
            req_size   = 2'($urandom);
            req_signed = 1'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);

        poke(6'd16, 32'h8899AABB);
        issue(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 1, 32'hFFFFFF88, 3, 0);
        issue(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 1, 32'h00008899, 3, 0);
        poke(6'd16, 32'h11223344);
        issue(1'b1, 2'b00, 1'b0, 32'h41, 32'h0000005A, 2, 32'h11225A44, 4, 0);
        issue(1'b1, 2'b10, 1'b0, 32'h80, 32'hDEADBEEF, 4, 32'h00000080, 2, 0);
        issue(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1, 32'hDEADBEEF, 3, 0);
`ifdef LSU_ALIGN_CHECK_EN
        issue(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 3, 32'h1, 1, 0);
`else
        issue(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 1, 32'h11225A44, 3, 0);
`endif
        issue(1'b0, 2'b00, 1'b0, 32'h42, 32'h0, 1, 32'h00000022, 3, 0);
        // Reset during the WAIT of a sub-word store: nothing may be written afterward.
        issue(1'b1, 2'b00, 1'b0, 32'h45, 32'h00000077, 0, 32'h0, 0, 2);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 250; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) poke(ra[7:2], $urandom);
            issue(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom, 0, 32'h0, 0, 0);
        end

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, meaning cycles from the MemRead cycle until memory data is valid (legal range 1..4).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, the CPU access request.
REQ-005 SHALL have port req_ready, output, 1, the unit is idle and accepts a request.
REQ-006 SHALL have port req_write, input, 1, meaning 1=store, 0=load.
REQ-007 SHALL have port req_size, input, 2, meaning 00=byte, 01=half, 10=word, 11=reserved.
REQ-008 SHALL have port req_signed, input, 1, meaning sign-extend sub-word loads.
REQ-009 SHALL have port req_addr, input, 32, the byte address.
REQ-010 SHALL have port req_wdata, input, 32, the store data, right-justified.
REQ-011 SHALL have port resp_valid, output, 1, a one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32, the load result, valid with resp_valid.
REQ-013 SHALL have port resp_err, output, 1, meaning the access was rejected, valid with resp_valid.
REQ-014 SHALL have port addr, output, 32, the word address to memory.
REQ-015 SHALL have port MemRead, output, 1, the memory read strobe.
REQ-016 SHALL have port MemWrite, output, 1, the memory write strobe.
REQ-017 SHALL have port WrData, output, 32, the memory write word.
REQ-018 SHALL have port data, input, 32, the memory read word.

Function
REQ-019 SHALL implement states IDLE, RD, WAIT, WR, RESP; req_ready=1 only in IDLE.
REQ-020 SHALL capture all req_* fields on the cycle req_valid&req_ready and hold them until RESP; req_valid while busy SHALL be ignored.
REQ-021 SHALL drive addr = {captured addr[31:2], 2'b00}, held constant from RD through WR.
REQ-022 SHALL route a word store IDLE->WR->RESP, with MemWrite=1 for exactly the WR cycle and WrData=req_wdata.
REQ-023 SHALL route a load IDLE->RD->WAIT->RESP, with MemRead=1 for exactly the RD cycle; WAIT lasts RD_LATENCY cycles, and data SHALL be sampled on the last WAIT edge.
REQ-024 SHALL route a byte or half store IDLE->RD->WAIT->WR->RESP (read-modify-write): only the addressed lanes of the sampled word are replaced, and all other lanes are written back unchanged.
REQ-025 SHALL use little-endian byte lanes: a byte occupies bits 8*addr[1:0]+:8; a half occupies bits 16*addr[1]+:16.
REQ-026 SHALL make a load result the extracted lane, zero-extended, or sign-extended when req_signed=1; a word load is returned unchanged.
REQ-027 SHALL assert resp_valid for exactly the single RESP cycle, followed by IDLE; resp_rdata SHALL hold its value until the next RESP, and resp_rdata is 0 for stores.
REQ-028 SHALL ensure MemRead and MemWrite are never high in the same cycle and are low in IDLE, WAIT and RESP.
REQ-029 SHALL produce these latencies (request accepted at edge T, RD_LATENCY=1): word store resp at T+2; load resp at T+3; sub-word store resp at T+4.

Reset
REQ-030 SHALL, while rst=0, immediately force state IDLE, MemRead=0, MemWrite=0, resp_valid=0, resp_err=0, resp_rdata=0, addr=0, WrData=0 and req_ready=0.
REQ-031 SHALL abandon any access in progress on reset with no write issued afterward; req_ready=1 on the first cycle after rst rises.

Configuration
REQ-032 SHALL, with LSU_ALIGN_CHECK_EN defined, complete a misaligned half (addr[0]=1), a misaligned word (addr[1:0]!=0) or size 11 IDLE->RESP with resp_err=1, with no MemRead or MemWrite and resp_rdata=0.
REQ-033 SHALL, without LSU_ALIGN_CHECK_EN, keep resp_err constant 0, ignore offending low address bits (half uses addr[1], word uses none), and treat size 11 as a word.

Verification
REQ-034 SHALL pass this case: memory word 0x8899AABB at 0x40, load byte signed at 0x43 -> resp_rdata=0xFFFFFF88 at T+3, with one MemRead pulse.
REQ-035 SHALL pass this case: load half unsigned at 0x42 from 0x8899AABB -> resp_rdata=0x00008899.
REQ-036 SHALL pass this case: store byte 0x5A at 0x41 over 0x11223344 -> one MemRead, then MemWrite with WrData=0x11225A44, and resp at T+4.
REQ-037 SHALL pass this case: store word 0xDEADBEEF at 0x80 -> MemWrite at T+1 with addr=0x80, no MemRead, and resp at T+2.
REQ-038 SHALL pass this case: rst pulsed low during the WAIT of a sub-word store -> no MemWrite ever asserted, and req_ready=1 after release.
REQ-039 SHALL pass this case: with LSU_ALIGN_CHECK_EN, load word at 0x42 -> resp_err=1 at T+1, with no memory strobes; without it, the same request reads 0x40.
